// File: rtl/shift_seq_ctrl_if.sv
// Command and response handshake bundle between a bus-side command source
// and the shift_seq_ctrl sequencer.
interface shift_seq_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int LEN_W = $clog2(WIDTH + 1)
);
   logic             cmd_valid_i;
   logic             cmd_ready_o;
   logic [WIDTH-1:0] cmd_data_i;
   logic [LEN_W-1:0] cmd_len_i;
   logic             cmd_dir_i;
   logic             rsp_valid_o;
   logic             rsp_ready_i;
   logic [WIDTH-1:0] rsp_data_o;

   modport master (
      output cmd_valid_i, cmd_data_i, cmd_len_i, cmd_dir_i, rsp_ready_i,
      input  cmd_ready_o, rsp_valid_o, rsp_data_o
   );

   modport slave (
      input  cmd_valid_i, cmd_data_i, cmd_len_i, cmd_dir_i, rsp_ready_i,
      output cmd_ready_o, rsp_valid_o, rsp_data_o
   );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequencer for one shift_reg: takes a command, loads the register, issues a
// paced burst of shift enables, then hands the shifted word back.
module shift_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int DIV   = 4,
   parameter int LEN_W = $clog2(WIDTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   shift_seq_ctrl_if.slave  bus,
   input  logic             abort_i,
   output logic             busy_o,
   output logic             sr_load_o,
   output logic             sr_en_o,
   output logic             sr_dir_o,
   output logic [WIDTH-1:0] sr_parallel_o,
   input  logic [WIDTH-1:0] sr_data_i
);
   localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(WIDTH);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, RESP} state_t;

   state_t           state;
   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] len_q;
   logic [DIV_W-1:0] div;
   logic             dir_q;
   logic [WIDTH-1:0] data_q;
   logic             cmd_ready_q;
   logic             rsp_valid_q;
   logic             busy_q;
   logic             load_q;
   logic             en_q;

   // Every control output is registered alongside the state so that nothing
   // depends combinationally on the handshake inputs. The shift enable is
   // therefore computed one cycle ahead from the divider's next value.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         cnt         <= '0;
         len_q       <= '0;
         div         <= '0;
         dir_q       <= 1'b0;
         data_q      <= '0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         load_q      <= 1'b0;
         en_q        <= 1'b0;
      end else if (state != IDLE && (abort_i || (state == RESP && bus.rsp_ready_i))) begin
         state       <= IDLE;
         cnt         <= '0;
         div         <= '0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         load_q      <= 1'b0;
         en_q        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid_i) begin
                  dir_q       <= bus.cmd_dir_i;
                  data_q      <= bus.cmd_data_i;
                  len_q       <= (bus.cmd_len_i > LEN_MAX) ? LEN_MAX : bus.cmd_len_i;
                  state       <= LOAD;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  load_q      <= 1'b1;
               end
            end
            LOAD: begin
               load_q <= 1'b0;
               div    <= '0;
               cnt    <= '0;
               if (len_q != '0) begin
                  state <= SHIFT;
                  en_q  <= (DIV_LAST == '0);
               end else begin
                  state       <= RESP;
                  rsp_valid_q <= 1'b1;
               end
            end
            SHIFT: begin
               // The cycle with div at its last value is the one carrying the pulse
               if (div == DIV_LAST) begin
                  div <= '0;
                  cnt <= cnt + 1'b1;
                  if (cnt == len_q - 1'b1) begin
                     state       <= RESP;
                     en_q        <= 1'b0;
                     rsp_valid_q <= 1'b1;
                  end else begin
                     en_q <= (DIV_LAST == '0);
                  end
               end else begin
                  div  <= div + 1'b1;
                  en_q <= (div + 1'b1 == DIV_LAST);
               end
            end
            RESP: begin
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cmd_ready_o = cmd_ready_q;
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_data_o  = rsp_valid_q ? sr_data_i : '0;
   assign busy_o          = busy_q;
   assign sr_load_o       = load_q;
   assign sr_en_o         = en_q;
   assign sr_dir_o        = dir_q;
   assign sr_parallel_o   = data_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl with a behavioural shift register
// (non-circular, zero serial input) attached to the sr_* pins.
module tb_shift_seq_ctrl;
   localparam int WIDTH = 8;
   localparam int DIV   = 2;
   localparam int LEN_W = $clog2(WIDTH + 1);
   localparam logic [31:0] RESET_VEC = 32'h0020_0000;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               len;
      logic             dir;
      int               hold;
      logic             immediate;
      logic [WIDTH-1:0] exp_rsp;
      int               exp_pulses;
      int               exp_cycle;
   } vec_t;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             abort_i;
   logic             busy_o;
   logic             sr_load_o;
   logic             sr_en_o;
   logic             sr_dir_o;
   logic [WIDTH-1:0] sr_parallel_o;
   logic [WIDTH-1:0] sr_data_i;
   int               checks = 0;
   int               failures = 0;

   shift_seq_ctrl_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

   shift_seq_ctrl #(.WIDTH(WIDTH), .DIV(DIV), .LEN_W(LEN_W)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .bus           (bus),
      .abort_i       (abort_i),
      .busy_o        (busy_o),
      .sr_load_o     (sr_load_o),
      .sr_en_o       (sr_en_o),
      .sr_dir_o      (sr_dir_o),
      .sr_parallel_o (sr_parallel_o),
      .sr_data_i     (sr_data_i)
   );

   always #5 clk_i = ~clk_i;

   // Shift register datapath being sequenced
   always @(posedge clk_i) begin
      if (rst_i)
         sr_data_i <= '0;
      else if (sr_load_o)
         sr_data_i <= sr_parallel_o;
      else if (sr_en_o)
         sr_data_i <= sr_dir_o ? {1'b0, sr_data_i[WIDTH-1:1]} : {sr_data_i[WIDTH-2:0], 1'b0};
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] outputVector();
      return 32'({bus.cmd_ready_o, bus.rsp_valid_o, busy_o, sr_load_o, sr_en_o,
                  sr_dir_o, bus.rsp_data_o, sr_parallel_o});
   endfunction

   function automatic int clampLen(input int len);
      return (len > WIDTH) ? WIDTH : len;
   endfunction

   // Result of shifting the loaded word n times with zeros entering
   function automatic logic [WIDTH-1:0] refResult(input logic [WIDTH-1:0] d, input int len, input logic dir);
      int n;
      int v;
      n = clampLen(len);
      v = int'(d);
      if (dir)
         v = v >> n;
      else
         v = (v << n) % (1 << WIDTH);
      return WIDTH'(v);
   endfunction

   // Leaves the bench in cycle 1 (the cycle after the command handshake)
   task automatic issueCommand(input logic [WIDTH-1:0] data, input int len, input logic dir,
                               input string tag, output int waited);
      waited = 0;
      while (!bus.cmd_ready_o && waited < 100) begin
         step();
         waited++;
      end
      checkOutput({tag, "_ready"}, 32'(bus.cmd_ready_o), 32'd1);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_data_i  = data;
      bus.cmd_len_i   = LEN_W'(len);
      bus.cmd_dir_i   = dir;
      step();
      bus.cmd_valid_i = 1'b0;
      bus.cmd_data_i  = WIDTH'($urandom);
      bus.cmd_len_i   = LEN_W'($urandom);
      bus.cmd_dir_i   = 1'($urandom);
      checkOutput({tag, "_load"}, 32'({sr_load_o, sr_en_o, busy_o, bus.cmd_ready_o}), 32'(4'b1010));
      checkOutput({tag, "_latched"}, 32'({sr_dir_o, sr_parallel_o}), 32'({dir, data}));
   endtask

   // Runs from cycle 1 through the response handshake, ending at cycle R+1
   task automatic finishCommand(input vec_t v, input string tag);
      int   cycle;
      int   pulses;
      int   resp_cycle;
      logic timing_ok;
      logic stable;
      cycle      = 1;
      pulses     = 0;
      resp_cycle = -1;
      timing_ok  = 1'b1;
      while (resp_cycle < 0 && cycle < 300) begin
         step();
         cycle++;
         if (sr_en_o) begin
            pulses++;
            if ((cycle - 1) % DIV != 0 || cycle < 1 + DIV) timing_ok = 1'b0;
         end
         if (sr_load_o) timing_ok = 1'b0;
         if (bus.rsp_valid_o) resp_cycle = cycle;
      end
      if (resp_cycle < 0) begin
         checkOutput({tag, "_rsp_timeout"}, 32'd0, 32'd1);
         return;
      end
      checkOutput({tag, "_pulses"}, 32'(pulses), 32'(v.exp_pulses));
      checkOutput({tag, "_pulse_timing"}, 32'(timing_ok), 32'd1);
      checkOutput({tag, "_rsp_cycle"}, 32'(resp_cycle), 32'(v.exp_cycle));
      checkOutput({tag, "_rsp_data"}, 32'(bus.rsp_data_o), 32'(v.exp_rsp));
      stable = 1'b1;
      for (int i = 0; i < v.hold; i++) begin
         step();
         if (!bus.rsp_valid_o || bus.rsp_data_o !== v.exp_rsp || sr_en_o || sr_load_o) stable = 1'b0;
      end
      checkOutput({tag, "_rsp_hold"}, 32'(stable), 32'd1);
      bus.rsp_ready_i = 1'b1;
      step();
      bus.rsp_ready_i = 1'b0;
      checkOutput({tag, "_idle_after_rsp"},
                  32'({bus.cmd_ready_o, bus.rsp_valid_o, busy_o, bus.rsp_data_o}), 32'({3'b100, 8'h00}));
      checkOutput({tag, "_latch_held"}, 32'({sr_dir_o, sr_parallel_o}), 32'({v.dir, v.data}));
   endtask

   task automatic applyStimulus(input vec_t v, input string tag);
      int waited;
      issueCommand(v.data, v.len, v.dir, tag, waited);
      if (v.immediate) checkOutput({tag, "_accept_gap"}, 32'(waited), 32'd0);
      finishCommand(v, tag);
   endtask

   initial begin
      vec_t vectors [6];
      vec_t v;
      int   waited;
      logic seen;

      vectors[0] = '{8'h01, 3,  1'b0, 0, 1'b0, 8'h08, 3, 8};
      vectors[1] = '{8'h80, 2,  1'b1, 5, 1'b0, 8'h20, 2, 6};
      vectors[2] = '{8'hA5, 0,  1'b0, 0, 1'b0, 8'hA5, 0, 2};
      vectors[3] = '{8'hFF, 15, 1'b0, 0, 1'b0, 8'h00, 8, 18};
      vectors[4] = '{8'h03, 1,  1'b0, 0, 1'b0, 8'h06, 1, 4};
      vectors[5] = '{8'hC0, 1,  1'b1, 0, 1'b1, 8'h60, 1, 4};

      bus.cmd_valid_i = 1'b0;
      bus.cmd_data_i  = '0;
      bus.cmd_len_i   = '0;
      bus.cmd_dir_i   = 1'b0;
      bus.rsp_ready_i = 1'b0;
      abort_i         = 1'b0;
      rst_i           = 1'b1;
      step();
      step();
      checkOutput("reset_state", outputVector(), RESET_VEC);
      rst_i = 1'b0;
      step();
      checkOutput("post_reset_idle", outputVector(), RESET_VEC);

      for (int i = 0; i < 6; i++)
         applyStimulus(vectors[i], $sformatf("vec%0d", i));

      // Abort while idle is ignored
      abort_i = 1'b1;
      step();
      step();
      abort_i = 1'b0;
      checkOutput("abort_in_idle", 32'({bus.cmd_ready_o, busy_o}), 32'(2'b10));

      // Abort in the second shift cycle
      issueCommand(8'h5A, 6, 1'b0, "abort", waited);
      step();
      step();
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      checkOutput("abort_to_idle", 32'({bus.cmd_ready_o, busy_o, bus.rsp_valid_o, sr_en_o}), 32'(4'b1000));
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.rsp_valid_o || sr_en_o || sr_load_o) seen = 1'b0 | 1'b1;
      end
      checkOutput("abort_no_activity", 32'(seen), 32'd0);
      v = '{8'h81, 1, 1'b1, 0, 1'b0, 8'h40, 1, 4};
      applyStimulus(v, "after_abort");

      // Command and abort together in idle: the command wins
      bus.cmd_valid_i = 1'b1;
      bus.cmd_data_i  = 8'h3C;
      bus.cmd_len_i   = LEN_W'(2);
      bus.cmd_dir_i   = 1'b1;
      abort_i         = 1'b1;
      step();
      bus.cmd_valid_i = 1'b0;
      abort_i         = 1'b0;
      checkOutput("cmd_with_abort_load", 32'({sr_load_o, busy_o}), 32'(2'b11));
      v = '{8'h3C, 2, 1'b1, 1, 1'b0, 8'h0F, 2, 6};
      finishCommand(v, "cmd_with_abort");

      // Synchronous reset in the middle of a burst
      issueCommand(8'hFF, 8, 1'b1, "midreset", waited);
      step();
      step();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      checkOutput("midreset_outputs", outputVector(), RESET_VEC);

      for (int i = 0; i < 16; i++) begin
         v.data       = WIDTH'($urandom);
         v.len        = int'($urandom_range(0, 15));
         v.dir        = 1'($urandom);
         v.hold       = int'($urandom_range(0, 3));
         v.immediate  = 1'b0;
         v.exp_rsp    = refResult(v.data, v.len, v.dir);
         v.exp_pulses = clampLen(v.len);
         v.exp_cycle  = 2 + DIV * clampLen(v.len);
         applyStimulus(v, $sformatf("rand%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout actual=running expected=finished");
      $fatal(1, "[TB] global timeout");
   end
endmodule
